// File: rtl/hazard_scoreboard_if.sv
// Bundle between the pipeline control and the hazard scoreboard.
//
// Handshake: the decode slot offers an instruction when issue_d=1 (valid).
// The scoreboard accepts it on the next rising edge only when stall_d=0 and
// flush_e=0 (ready = ~stall_d & ~flush_e). While stall_d=1 the pipeline must
// hold the decode fields stable so the same instruction is offered again.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic              use_rs1_d;
    logic              use_rs2_d;
    logic [REG_AW-1:0] rd_d;
    logic              regwrite_d;
    logic              load_d;
    logic              issue_d;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic              branch_taken_e;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic [2:0]        fwd_a_e;
    logic [2:0]        fwd_b_e;
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;

    // Pipeline side: drives decode/execute information, receives control.
    modport master (
        output rs1_d, rs2_d, use_rs1_d, use_rs2_d, rd_d, regwrite_d, load_d,
               issue_d, rs1_e, rs2_e, branch_taken_e,
        input  stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
               stall_cnt, flush_cnt
    );

    // Scoreboard side.
    modport slave (
        input  rs1_d, rs2_d, use_rs1_d, use_rs2_d, rd_d, regwrite_d, load_d,
               issue_d, rs1_e, rs2_e, branch_taken_e,
        output stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadows the destination of every instruction in the
// stages after decode (entry 0 = E ... entry DEPTH-1 = W), selects operand
// forwarding for the execute stage, and interlocks decode on hazards that
// forwarding cannot cover. Branch redirects flush and override any stall.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave bus
);

    // Shadow entries, one per tracked stage.
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  wr_q, wr_d;
    logic [DEPTH-1:0]  load_q, load_d;
    logic [REG_AW-1:0] ent_rd_q [DEPTH];
    logic [REG_AW-1:0] ent_rd_d [DEPTH];

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Producer matches: decode sources against stages that can still block
    // decode, execute sources against stages that can forward (k >= 1).
    logic [DEPTH-2:0] hit_rs1_d, hit_rs2_d;
    logic [DEPTH-1:1] hit_rs1_e, hit_rs2_e;

    logic       use1, use2;
    logic       hazard, stall, flush, accept;
    logic [2:0] fwd_a, fwd_b;

    // Match each entry as a producer; register 0 never produces anything.
    always_comb begin
        hit_rs1_d = '0;
        hit_rs2_d = '0;
        hit_rs1_e = '0;
        hit_rs2_e = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            hit_rs1_d[k] = valid_q[k] & wr_q[k] & (ent_rd_q[k] != '0) & (ent_rd_q[k] == bus.rs1_d);
            hit_rs2_d[k] = valid_q[k] & wr_q[k] & (ent_rd_q[k] != '0) & (ent_rd_q[k] == bus.rs2_d);
        end
        for (int k = 1; k < DEPTH; k++) begin
            hit_rs1_e[k] = valid_q[k] & wr_q[k] & (ent_rd_q[k] != '0) & (ent_rd_q[k] == bus.rs1_e);
            hit_rs2_e[k] = valid_q[k] & wr_q[k] & (ent_rd_q[k] != '0) & (ent_rd_q[k] == bus.rs2_e);
        end
    end

    // Hazard: with forwarding only a load in E blocks a dependent decode;
    // without it any producer not yet at W blocks (W writes before read).
    always_comb begin
        use1   = bus.issue_d & bus.use_rs1_d;
        use2   = bus.issue_d & bus.use_rs2_d;
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = load_q[0] & ((use1 & hit_rs1_d[0]) | (use2 & hit_rs2_d[0]));
        end else begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                hazard = hazard | (use1 & hit_rs1_d[k]) | (use2 & hit_rs2_d[k]);
            end
        end
        flush = bus.branch_taken_e;
        stall = hazard & ~bus.branch_taken_e;
    end

    // Forward select: scan oldest to youngest so the youngest producer wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        if (FWD_EN != 0) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (hit_rs1_e[k]) fwd_a = 3'(k);
                if (hit_rs2_e[k]) fwd_b = 3'(k);
            end
        end
    end

    // Next entries: shift down the pipe, insert decode or a bubble at E.
    always_comb begin
        valid_d  = '0;
        wr_d     = '0;
        load_d   = '0;
        ent_rd_d = '{default: '0};
        accept   = ~stall & ~flush;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k]  = valid_q[k-1];
            wr_d[k]     = wr_q[k-1];
            load_d[k]   = load_q[k-1];
            ent_rd_d[k] = ent_rd_q[k-1];
        end
        valid_d[0]  = accept & bus.issue_d;
        wr_d[0]     = accept & bus.regwrite_d;
        load_d[0]   = accept & bus.load_d;
        ent_rd_d[0] = bus.rd_d;
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    // State registers; reset discards every in-flight entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            wr_q        <= '0;
            load_q      <= '0;
            ent_rd_q    <= '{default: '0};
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            wr_q        <= wr_d;
            load_q      <= load_d;
            ent_rd_q    <= ent_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_f   = stall;
    assign bus.stall_d   = stall;
    assign bus.flush_d   = flush;
    assign bus.flush_e   = flush;
    assign bus.fwd_a_e   = fwd_a;
    assign bus.fwd_b_e   = fwd_b;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a forwarding instance (DEPTH=3) and a
// stall-only instance (DEPTH=4) see the same stimulus; both are compared
// against an age-based model of instructions in flight.
module tb_hazard_scoreboard;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(5)) bus_a ();
    hazard_scoreboard_if #(.REG_AW(5)) bus_b ();

    hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .FWD_EN(1)) dut_fwd (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    hazard_scoreboard #(.REG_AW(5), .DEPTH(4), .FWD_EN(0)) dut_stl (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // ---------------- stimulus record ----------------
    typedef struct {
        logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e;
        logic       use1, use2, wr, load, issue, br;
    } stim_t;
    stim_t s;

    // ---------------- reference model ----------------
    // Each in-flight instruction is remembered with its age in cycles since
    // entering E; age equals its stage index until it passes W.
    typedef struct {
        logic [4:0] rd;
        bit         wr;
        bit         load;
        int         age;
    } rec_t;
    typedef rec_t rq_t[$];
    rq_t q_a, q_b;

    bit          es_a, ef_a, es_b, ef_b;
    logic [2:0]  efa_a, efb_a, efa_b, efb_b;
    int unsigned ecs_a, ecf_a, ecs_b, ecf_b;

    int checks   = 0;
    int failures = 0;

    function automatic void model_out(input rq_t q, input int depth, input bit fwd_en,
                                      output bit stall, output bit flush,
                                      output logic [2:0] fa, output logic [2:0] fb);
        bit hazard = 0;
        int ba = depth;
        int bb = depth;
        foreach (q[i]) begin
            if (q[i].wr && q[i].rd != 5'd0) begin
                if (q[i].age >= 1 && q[i].rd == s.rs1_e && q[i].age < ba) ba = q[i].age;
                if (q[i].age >= 1 && q[i].rd == s.rs2_e && q[i].age < bb) bb = q[i].age;
                if (s.issue && ((s.use1 && q[i].rd == s.rs1_d) || (s.use2 && q[i].rd == s.rs2_d))) begin
                    if (fwd_en ? (q[i].age == 0 && q[i].load) : (q[i].age <= depth - 2)) hazard = 1;
                end
            end
        end
        fa    = (fwd_en && ba < depth) ? 3'(ba) : 3'd0;
        fb    = (fwd_en && bb < depth) ? 3'(bb) : 3'd0;
        flush = s.br;
        stall = hazard && !s.br;
    endfunction

    function automatic rq_t model_adv(input rq_t q, input int depth, input bit accept);
        rq_t n;
        n = {};
        foreach (q[i]) begin
            rec_t r;
            r = q[i];
            r.age = r.age + 1;
            if (r.age < depth) n.push_back(r);
        end
        if (accept && s.issue) n.push_back(rec_t'{rd: s.rd_d, wr: s.wr, load: s.load, age: 0});
        return n;
    endfunction

    function automatic void model_clear();
        q_a = {};
        q_b = {};
        ecs_a = 0; ecf_a = 0; ecs_b = 0; ecf_b = 0;
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        s = '{default: '0};
    endtask

    task automatic drive();
        bus_a.rs1_d = s.rs1_d;  bus_b.rs1_d = s.rs1_d;
        bus_a.rs2_d = s.rs2_d;  bus_b.rs2_d = s.rs2_d;
        bus_a.use_rs1_d = s.use1;  bus_b.use_rs1_d = s.use1;
        bus_a.use_rs2_d = s.use2;  bus_b.use_rs2_d = s.use2;
        bus_a.rd_d = s.rd_d;  bus_b.rd_d = s.rd_d;
        bus_a.regwrite_d = s.wr;  bus_b.regwrite_d = s.wr;
        bus_a.load_d = s.load;  bus_b.load_d = s.load;
        bus_a.issue_d = s.issue;  bus_b.issue_d = s.issue;
        bus_a.rs1_e = s.rs1_e;  bus_b.rs1_e = s.rs1_e;
        bus_a.rs2_e = s.rs2_e;  bus_b.rs2_e = s.rs2_e;
        bus_a.branch_taken_e = s.br;  bus_b.branch_taken_e = s.br;
    endtask

    // Apply the stimulus mid-cycle and compare every output with the model.
    task automatic apply_check();
        @(negedge clk);
        drive();
        #1;
        model_out(q_a, 3, 1'b1, es_a, ef_a, efa_a, efb_a);
        model_out(q_b, 4, 1'b0, es_b, ef_b, efa_b, efb_b);
        chk("a.stall_f", 32'(bus_a.stall_f), 32'(es_a));
        chk("a.stall_d", 32'(bus_a.stall_d), 32'(es_a));
        chk("a.flush_d", 32'(bus_a.flush_d), 32'(ef_a));
        chk("a.flush_e", 32'(bus_a.flush_e), 32'(ef_a));
        chk("a.fwd_a_e", 32'(bus_a.fwd_a_e), 32'(efa_a));
        chk("a.fwd_b_e", 32'(bus_a.fwd_b_e), 32'(efb_a));
        chk("a.stall_cnt", bus_a.stall_cnt, ecs_a);
        chk("a.flush_cnt", bus_a.flush_cnt, ecf_a);
        chk("b.stall_f", 32'(bus_b.stall_f), 32'(es_b));
        chk("b.stall_d", 32'(bus_b.stall_d), 32'(es_b));
        chk("b.flush_d", 32'(bus_b.flush_d), 32'(ef_b));
        chk("b.flush_e", 32'(bus_b.flush_e), 32'(ef_b));
        chk("b.fwd_a_e", 32'(bus_b.fwd_a_e), 32'(efa_b));
        chk("b.fwd_b_e", 32'(bus_b.fwd_b_e), 32'(efb_b));
        chk("b.stall_cnt", bus_b.stall_cnt, ecs_b);
        chk("b.flush_cnt", bus_b.flush_cnt, ecf_b);
    endtask

    // Clock edge: advance the model the same way the pipeline advances.
    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            q_a = model_adv(q_a, 3, !es_a && !ef_a);
            q_b = model_adv(q_b, 4, !es_b && !ef_b);
            if (es_a && ecs_a != 32'hFFFF_FFFF) ecs_a++;
            if (ef_a && ecf_a != 32'hFFFF_FFFF) ecf_a++;
            if (es_b && ecs_b != 32'hFFFF_FFFF) ecs_b++;
            if (ef_b && ecf_b != 32'hFFFF_FFFF) ecf_b++;
        end
        #1;
    endtask

    task automatic cycle();
        apply_check();
        advance();
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        drive();
        rst = 1'b0;
        #1;
        model_clear();
        chk("rst.a.stall_d", 32'(bus_a.stall_d), 32'd0);
        chk("rst.a.fwd_a_e", 32'(bus_a.fwd_a_e), 32'd0);
        chk("rst.a.stall_cnt", bus_a.stall_cnt, 32'd0);
        chk("rst.b.flush_cnt", bus_b.flush_cnt, 32'd0);
        advance();
        rst = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        idle();
        drive();
        do_reset();
        cycle();

        // add x5 flows E -> M -> W; consumer in E sees stage index.
        idle(); s.issue = 1; s.rd_d = 5'd5; s.wr = 1;
        cycle();
        idle(); s.rs1_e = 5'd5;
        apply_check(); chk("fwd.x5.E", 32'(bus_a.fwd_a_e), 32'd0); advance();
        apply_check(); chk("fwd.x5.M", 32'(bus_a.fwd_a_e), 32'd1); advance();
        apply_check(); chk("fwd.x5.W", 32'(bus_a.fwd_a_e), 32'd2); advance();
        apply_check(); chk("fwd.x5.gone", 32'(bus_a.fwd_a_e), 32'd0); advance();

        // load x7 then dependent on rs2: one bubble, then forward from W.
        do_reset();
        idle(); s.issue = 1; s.rd_d = 5'd7; s.wr = 1; s.load = 1;
        cycle();
        idle(); s.issue = 1; s.rd_d = 5'd8; s.wr = 1; s.rs2_d = 5'd7; s.use2 = 1;
        apply_check(); chk("lu.stall_f", 32'(bus_a.stall_f), 32'd1);
                       chk("lu.stall_d", 32'(bus_a.stall_d), 32'd1); advance();
        apply_check(); chk("lu.released", 32'(bus_a.stall_d), 32'd0); advance();
        idle(); s.rs2_e = 5'd7;
        apply_check(); chk("lu.fwd_b_e", 32'(bus_a.fwd_b_e), 32'd2);
                       chk("lu.stall_cnt", bus_a.stall_cnt, 32'd1); advance();

        // x3 at M and W together: youngest wins.
        do_reset();
        idle(); s.issue = 1; s.rd_d = 5'd3; s.wr = 1;
        cycle();
        cycle();
        idle();
        cycle();
        idle(); s.rs1_e = 5'd3;
        apply_check(); chk("young.fwd_a_e", 32'(bus_a.fwd_a_e), 32'd1); advance();

        // load-use and taken branch in the same cycle: flush wins.
        do_reset();
        idle(); s.issue = 1; s.rd_d = 5'd7; s.wr = 1; s.load = 1;
        cycle();
        idle(); s.issue = 1; s.rs1_d = 5'd7; s.use1 = 1; s.br = 1;
        apply_check(); chk("br.stall_d", 32'(bus_a.stall_d), 32'd0);
                       chk("br.flush_d", 32'(bus_a.flush_d), 32'd1);
                       chk("br.flush_e", 32'(bus_a.flush_e), 32'd1); advance();
        idle();
        apply_check(); chk("br.flush_cnt", bus_a.flush_cnt, 32'd1);
                       chk("br.stall_cnt", bus_a.stall_cnt, 32'd0); advance();

        // Stall-only, DEPTH=4: dependent on x9 waits three cycles.
        do_reset();
        idle(); s.issue = 1; s.rd_d = 5'd9; s.wr = 1;
        cycle();
        idle(); s.issue = 1; s.rs1_d = 5'd9; s.use1 = 1; s.rs1_e = 5'd9; s.rs2_e = 5'd9;
        for (int i = 0; i < 3; i++) begin
            apply_check(); chk("nf.stall_d", 32'(bus_b.stall_d), 32'd1);
                           chk("nf.fwd_a_e", 32'(bus_b.fwd_a_e), 32'd0); advance();
        end
        apply_check(); chk("nf.released", 32'(bus_b.stall_d), 32'd0);
                       chk("nf.stall_cnt", bus_b.stall_cnt, 32'd3); advance();

        // Writes to x0 never forward.
        do_reset();
        idle(); s.issue = 1; s.rd_d = 5'd0; s.wr = 1;
        cycle();
        idle();
        cycle();
        idle(); s.rs1_e = 5'd0;
        apply_check(); chk("x0.fwd_a_e", 32'(bus_a.fwd_a_e), 32'd0); advance();

        // Reset asserted mid-stall clears stall and counters at once.
        idle(); s.issue = 1; s.rd_d = 5'd9; s.wr = 1;
        cycle();
        idle(); s.issue = 1; s.rs1_d = 5'd9; s.use1 = 1; s.rs1_e = 5'd9;
        apply_check(); chk("mid.pre.stall_d", 32'(bus_b.stall_d), 32'd1);
        #1 rst = 1'b0;
        #1;
        model_clear();
        chk("mid.stall_d", 32'(bus_b.stall_d), 32'd0);
        chk("mid.stall_cnt", bus_b.stall_cnt, 32'd0);
        chk("mid.flush_cnt", bus_a.flush_cnt, 32'd0);
        advance();
        rst = 1'b1;
        apply_check(); chk("mid.after.stall_d", 32'(bus_b.stall_d), 32'd0);
                       chk("mid.after.fwd_a_e", 32'(bus_a.fwd_a_e), 32'd0); advance();

        // Randomized traffic on a small register set to force collisions.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            s.rs1_d = 5'($urandom_range(0, 3));
            s.rs2_d = 5'($urandom_range(0, 3));
            s.rd_d  = 5'($urandom_range(0, 3));
            s.rs1_e = 5'($urandom_range(0, 3));
            s.rs2_e = 5'($urandom_range(0, 3));
            s.use1  = 1'($urandom_range(0, 1));
            s.use2  = 1'($urandom_range(0, 1));
            s.wr    = 1'($urandom_range(0, 3) != 0);
            s.load  = 1'($urandom_range(0, 2) == 0);
            s.issue = 1'($urandom_range(0, 3) != 0);
            s.br    = 1'($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, tracked stages after decode (index 0=E, 1=M, ..., DEPTH-1=W); legal range 2..6.
REQ-003 SHALL have parameter FWD_EN, default 1, forwarding enabled (0 = stall-only interlock).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports rs1_d, rs2_d  input  REG_AW  decode source registers; use_rs1_d, use_rs2_d  input  1  source actually read.
REQ-007 SHALL have ports rd_d  input  REG_AW; regwrite_d, load_d, issue_d  input  1  decode destination, writes reg, is load, decode slot valid.
REQ-008 SHALL have ports rs1_e, rs2_e  input  REG_AW  execute-stage sources.
REQ-009 SHALL have port branch_taken_e  input  1  execute-stage redirect.
REQ-010 SHALL have ports stall_f, stall_d, flush_d, flush_e  output  1  pipeline control.
REQ-011 SHALL have ports fwd_a_e, fwd_b_e  output  3  forward select: 0 = register file, k = stage index k.
REQ-012 SHALL have ports stall_cnt, flush_cnt  output  32  performance counters.

Function
REQ-013 SHALL hold per stage k a shadow entry {valid, rd, wr, load}.
REQ-014 SHALL, each rising edge, shift entry k-1 into k for k = 1..DEPTH-1; entry DEPTH-1 retires.
REQ-015 SHALL load entry 0 with {issue_d, rd_d, regwrite_d, load_d} when neither stall_d nor flush_e; else load a bubble (valid=0).
REQ-016 SHALL treat an entry as a producer for register r only if valid & wr & rd!=0 & rd==r; r=0 never matches.
REQ-017 SHALL, when FWD_EN=1, drive fwd_a_e (fwd_b_e) combinationally to the lowest k in 1..DEPTH-1 whose entry produces rs1_e (rs2_e); 0 if none (youngest wins).
REQ-018 SHALL, when FWD_EN=0, drive fwd_a_e and fwd_b_e to 0.
REQ-019 SHALL, when FWD_EN=1, raise hazard when entry 0 is a load producing a used decode source (load-use, one bubble).
REQ-020 SHALL, when FWD_EN=0, raise hazard when any entry k in 0..DEPTH-2 produces a used decode source (register file is write-before-read at W).
REQ-021 SHALL drive stall_f = stall_d = hazard & ~branch_taken_e.
REQ-022 SHALL drive flush_d = flush_e = branch_taken_e; flush overrides stall in the same cycle.
REQ-023 SHALL ignore unused sources (use_rsX_d=0) and non-valid decode slot (issue_d=0) for hazard detection.
REQ-024 SHALL increment stall_cnt on each edge where stall_d=1, saturating at 32'hFFFF_FFFF.
REQ-025 SHALL increment flush_cnt on each edge where flush_e=1, saturating at 32'hFFFF_FFFF.
REQ-026 SHALL produce all outputs except counters combinationally from current entries and inputs (zero added latency).

Reset
REQ-027 SHALL, while rst=0, asynchronously clear all entries to invalid and both counters to 0.
REQ-028 SHALL, with all entries invalid and branch_taken_e=0, output stall_f=stall_d=flush_d=flush_e=0 and fwd_a_e=fwd_b_e=0.
REQ-029 SHALL discard in-flight entries on reset mid-operation; no forward or stall survives reset deassertion.

Verification
REQ-030 SHALL cover: add x5 issued, next cycle rs1_e=5 -> fwd_a_e=1; one cycle later (producer at W, DEPTH=3) -> fwd_a_e=2.
REQ-031 SHALL cover: load x7 in entry 0, rs2_d=7, use_rs2_d=1 -> stall_f=stall_d=1 one cycle, bubble in entry 0, then fwd_b_e=2, stall_cnt=1.
REQ-032 SHALL cover: x3 written at stages 1 and 2 simultaneously, rs1_e=3 -> fwd_a_e=1.
REQ-033 SHALL cover: load-use hazard and branch_taken_e=1 same cycle -> stall_d=0, flush_d=flush_e=1, flush_cnt=1, stall_cnt=0.
REQ-034 SHALL cover: FWD_EN=0, DEPTH=4, add x9 then dependent on x9 -> stall_d=1 for 3 cycles, fwd outputs stay 0.
REQ-035 SHALL cover: rd_d=0 with regwrite_d=1, consumer rs1_e=0 -> fwd_a_e=0; rst=0 mid-stall -> stall_d=0, counters=0 immediately.
